// File: rtl/camera_window_capture_if.sv
// Sensor-side bus and capture outputs of camera_window_capture.
// master drives the sensor/config side, slave is the capture block.
interface camera_window_capture_if #(
    parameter int DATA_WIDTH = 10,
    parameter int MAX_COLS   = 752,
    parameter int MAX_LINES  = 480,
    parameter int FCNT_WIDTH = 8
);
    localparam int COL_BITS  = $clog2(MAX_COLS);
    localparam int LINE_BITS = $clog2(MAX_LINES);

    logic                  ENABLE;
    logic                  LINE_VALID;
    logic                  FRAME_VALID;
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic [COL_BITS-1:0]   WIN_X0;
    logic [COL_BITS-1:0]   WIN_W;
    logic [LINE_BITS-1:0]  WIN_Y0;
    logic [LINE_BITS-1:0]  WIN_H;
    logic                  DECIM_X;
    logic                  DECIM_Y;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic [LINE_BITS-1:0]  CURRENT_LINE;
    logic [COL_BITS-1:0]   CURRENT_COLUMN;
    logic                  PIXEL_VALID;
    logic                  FRAME_START;
    logic                  FRAME_END;
    logic [FCNT_WIDTH-1:0] FRAME_COUNT;
    logic                  GEOM_ERROR;

    modport master (
        output ENABLE, LINE_VALID, FRAME_VALID, DATA_IN,
               WIN_X0, WIN_W, WIN_Y0, WIN_H, DECIM_X, DECIM_Y,
        input  DATA_OUT, CURRENT_LINE, CURRENT_COLUMN, PIXEL_VALID,
               FRAME_START, FRAME_END, FRAME_COUNT, GEOM_ERROR
    );

    modport slave (
        input  ENABLE, LINE_VALID, FRAME_VALID, DATA_IN,
               WIN_X0, WIN_W, WIN_Y0, WIN_H, DECIM_X, DECIM_Y,
        output DATA_OUT, CURRENT_LINE, CURRENT_COLUMN, PIXEL_VALID,
               FRAME_START, FRAME_END, FRAME_COUNT, GEOM_ERROR
    );
endinterface

// File: rtl/camera_window_capture.sv
// Parallel-sensor capture: per-frame crop window, optional 2x decimation,
// window-relative coordinates, frame pulses/counter and sticky geometry error.
module camera_window_capture #(
    parameter int DATA_WIDTH = 10,
    parameter int MAX_COLS   = 752,
    parameter int MAX_LINES  = 480,
    parameter int FCNT_WIDTH = 8
) (
    input logic PIXCLK,
    input logic RESET,
    camera_window_capture_if.slave bus
);
    localparam int COL_BITS  = $clog2(MAX_COLS);
    localparam int LINE_BITS = $clog2(MAX_LINES);
    // one spare bit so window ends and saturated counters never wrap
    localparam int CW = COL_BITS + 1;
    localparam int LW = LINE_BITS + 1;

    typedef enum logic [1:0] {WAIT_IDLE, ARMED, ACTIVE} state_t;

    state_t        state, state_nxt;
    logic          enter, leave;
    logic [CW-1:0] x, x0, xe, dx;
    logic [LW-1:0] y, y0, ye, dy;
    logic          dec_x, dec_y;
    logic          lv_q, first_done;
    logic          pix, in_geom, in_win, keep;

    always_ff @(posedge PIXCLK or posedge RESET) begin
        if (RESET) state <= WAIT_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        enter     = 1'b0;
        leave     = 1'b0;
        case (state)
            WAIT_IDLE: if (!bus.FRAME_VALID) state_nxt = ARMED;
            ARMED: begin
                if (bus.FRAME_VALID) begin
                    if (bus.ENABLE) begin
                        state_nxt = ACTIVE;
                        enter     = 1'b1;
                    end else begin
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            ACTIVE: begin
                if (!bus.FRAME_VALID) begin
                    state_nxt = ARMED;
                    leave     = 1'b1;
                end
            end
            default: state_nxt = WAIT_IDLE;
        endcase
    end

    assign pix     = (state == ACTIVE) && bus.FRAME_VALID && bus.LINE_VALID;
    assign dx      = x - x0;
    assign dy      = y - y0;
    assign in_geom = (x < CW'(MAX_COLS)) && (y < LW'(MAX_LINES));
    assign in_win  = (x >= x0) && (x < xe) && (y >= y0) && (y < ye);
    assign keep    = pix && in_geom && in_win && !(dec_x && dx[0]) && !(dec_y && dy[0]);

    always_ff @(posedge PIXCLK or posedge RESET) begin
        if (RESET) begin
            x                  <= '0;
            y                  <= '0;
            x0                 <= '0;
            xe                 <= '0;
            y0                 <= '0;
            ye                 <= '0;
            dec_x              <= 1'b0;
            dec_y              <= 1'b0;
            lv_q               <= 1'b0;
            first_done         <= 1'b0;
            bus.DATA_OUT       <= '0;
            bus.CURRENT_LINE   <= '0;
            bus.CURRENT_COLUMN <= '0;
            bus.PIXEL_VALID    <= 1'b0;
            bus.FRAME_START    <= 1'b0;
            bus.FRAME_END      <= 1'b0;
            bus.FRAME_COUNT    <= '0;
            bus.GEOM_ERROR     <= 1'b0;
        end else begin
            lv_q            <= bus.LINE_VALID && bus.FRAME_VALID;
            bus.PIXEL_VALID <= keep;
            bus.FRAME_START <= keep && !first_done;
            bus.FRAME_END   <= leave;
            if (leave) bus.FRAME_COUNT <= bus.FRAME_COUNT + 1'b1;
            if (keep) begin
                bus.DATA_OUT       <= bus.DATA_IN;
                bus.CURRENT_COLUMN <= COL_BITS'(dx >> dec_x);
                bus.CURRENT_LINE   <= LINE_BITS'(dy >> dec_y);
            end
            if (enter) begin
                x0             <= CW'(bus.WIN_X0);
                xe             <= CW'(bus.WIN_X0) + CW'(bus.WIN_W);
                y0             <= LW'(bus.WIN_Y0);
                ye             <= LW'(bus.WIN_Y0) + LW'(bus.WIN_H);
                dec_x          <= bus.DECIM_X;
                dec_y          <= bus.DECIM_Y;
                x              <= '0;
                y              <= '0;
                lv_q           <= 1'b0;
                first_done     <= 1'b0;
                bus.GEOM_ERROR <= 1'b0;
            end else if (state == ACTIVE) begin
                if (pix) begin
                    if (!in_geom) bus.GEOM_ERROR <= 1'b1;
                    if (keep) first_done <= 1'b1;
                    if (x != CW'(MAX_COLS)) x <= x + 1'b1;
                end else if (!bus.LINE_VALID) begin
                    x <= '0;
                    // a line ended by FRAME_VALID falling is not counted
                    if (lv_q && bus.FRAME_VALID && (y != LW'(MAX_LINES))) y <= y + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_camera_window_capture.sv
// Randomized and directed bench for camera_window_capture against a
// frame-level model that lists expected pixels/frame ends per cycle.
module tb_camera_window_capture;
    localparam int DW = 10;
    localparam int MC = 4;
    localparam int ML = 4;
    localparam int FW = 8;
    localparam int CB = $clog2(MC);
    localparam int LB = $clog2(ML);

    logic PIXCLK = 1'b0;
    logic RESET;
    camera_window_capture_if #(.DATA_WIDTH(DW), .MAX_COLS(MC), .MAX_LINES(ML), .FCNT_WIDTH(FW)) bus();
    camera_window_capture #(.DATA_WIDTH(DW), .MAX_COLS(MC), .MAX_LINES(ML), .FCNT_WIDTH(FW)) dut (
        .PIXCLK(PIXCLK), .RESET(RESET), .bus(bus));

    always #5 PIXCLK = ~PIXCLK;

    typedef struct {int cyc; int data; int line; int col; bit fs;} pix_t;
    typedef struct {int cyc; int cnt;} end_t;
    pix_t pq[$];
    end_t eq[$];

    int cyc = 0;
    always @(posedge PIXCLK) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    int npix, fs_data, last_data;
    int fc_m = 0;
    bit err_m = 0;
    int w_x0, w_w, w_y0, w_h;
    bit w_dx, w_dy;
    int flen[8];
    int fpix[8][8];
    int nl;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    bit pe, ee;
    always @(negedge PIXCLK) begin
        if (!RESET) begin
            while (pq.size() > 0 && pq[0].cyc < cyc) void'(pq.pop_front());
            while (eq.size() > 0 && eq[0].cyc < cyc) void'(eq.pop_front());
            pe = pq.size() > 0 && pq[0].cyc == cyc;
            chk("pixel_valid", int'(bus.PIXEL_VALID), int'(pe));
            if (bus.PIXEL_VALID && pe) begin
                chk("data_out", int'(bus.DATA_OUT), pq[0].data);
                chk("current_line", int'(bus.CURRENT_LINE), pq[0].line);
                chk("current_column", int'(bus.CURRENT_COLUMN), pq[0].col);
                chk("frame_start", int'(bus.FRAME_START), int'(pq[0].fs));
                npix++;
                last_data = int'(bus.DATA_OUT);
                if (bus.FRAME_START) fs_data = int'(bus.DATA_OUT);
                void'(pq.pop_front());
            end else begin
                chk("frame_start_idle", int'(bus.FRAME_START), 0);
            end
            ee = eq.size() > 0 && eq[0].cyc == cyc;
            chk("frame_end", int'(bus.FRAME_END), int'(ee));
            if (ee) begin
                chk("frame_count_at_end", int'(bus.FRAME_COUNT), eq[0].cnt);
                void'(eq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge PIXCLK);
        #1;
    endtask

    task automatic set_win(input int x0, input int w, input int y0, input int h, input bit ddx, input bit ddy);
        w_x0 = x0; w_w = w; w_y0 = y0; w_h = h; w_dx = ddx; w_dy = ddy;
        bus.WIN_X0 = CB'(x0); bus.WIN_W = CB'(w);
        bus.WIN_Y0 = LB'(y0); bus.WIN_H = LB'(h);
        bus.DECIM_X = ddx; bus.DECIM_Y = ddy;
    endtask

    // mode 0: 10*(y+1)+(x+1), mode 1: 10*y+x, otherwise random
    task automatic setup_frame(input int lines, input int cols, input int mode);
        nl = lines;
        for (int y = 0; y < 8; y++) begin
            flen[y] = cols;
            for (int x = 0; x < 8; x++)
                fpix[y][x] = (mode == 0) ? 10 * (y + 1) + (x + 1) :
                             (mode == 1) ? 10 * y + x : int'($urandom_range(0, 1023));
        end
    endtask

    task automatic end_frame(input bit cap);
        bus.FRAME_VALID = 1'b0;
        bus.LINE_VALID  = 1'b0;
        if (cap) begin
            end_t e;
            fc_m = (fc_m + 1) % 256;
            e.cyc = cyc + 1;
            e.cnt = fc_m;
            eq.push_back(e);
        end
        tick();
        set_win(w_x0, w_w, w_y0, w_h, w_dx, w_dy);
        repeat ($urandom_range(0, 2)) tick();
        chk("geom_error_after_frame", int'(bus.GEOM_ERROR), int'(err_m));
    endtask

    task automatic run_frame(input bit en, input int drop_y, input int drop_x);
        bit first = 1'b1;
        bus.ENABLE      = en;
        bus.FRAME_VALID = 1'b1;
        bus.LINE_VALID  = 1'b0;
        tick();
        if (en) begin
            err_m = 1'b0;
            chk("geom_error_cleared", int'(bus.GEOM_ERROR), 0);
        end
        // later config changes must not affect the running frame
        bus.ENABLE  = 1'b1;
        bus.WIN_X0  = CB'($urandom);
        bus.WIN_W   = CB'($urandom);
        bus.WIN_Y0  = LB'($urandom);
        bus.WIN_H   = LB'($urandom);
        bus.DECIM_X = 1'($urandom);
        bus.DECIM_Y = 1'($urandom);
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < flen[y]; x++) begin
                if (y == drop_y && x == drop_x) begin
                    end_frame(en);
                    return;
                end
                bus.LINE_VALID = 1'b1;
                bus.DATA_IN    = DW'(fpix[y][x]);
                if (en) begin
                    if (x >= MC || y >= ML) err_m = 1'b1;
                    else if (x >= w_x0 && x < w_x0 + w_w && y >= w_y0 && y < w_y0 + w_h &&
                             !(w_dx && ((x - w_x0) % 2 == 1)) && !(w_dy && ((y - w_y0) % 2 == 1))) begin
                        pix_t p;
                        p.cyc  = cyc + 1;
                        p.data = fpix[y][x];
                        p.line = w_dy ? (y - w_y0) / 2 : (y - w_y0);
                        p.col  = w_dx ? (x - w_x0) / 2 : (x - w_x0);
                        p.fs   = first;
                        first  = 1'b0;
                        pq.push_back(p);
                    end
                end
                tick();
            end
            bus.LINE_VALID = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
        end
        end_frame(en);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_pixel_valid"}, int'(bus.PIXEL_VALID), 0);
        chk({tag, "_data_out"}, int'(bus.DATA_OUT), 0);
        chk({tag, "_frame_end"}, int'(bus.FRAME_END), 0);
        chk({tag, "_frame_count"}, int'(bus.FRAME_COUNT), 0);
        chk({tag, "_geom_error"}, int'(bus.GEOM_ERROR), 0);
    endtask

    initial begin
        RESET = 1'b1;
        bus.ENABLE = 1'b1;
        bus.FRAME_VALID = 1'b1;
        bus.LINE_VALID = 1'b1;
        bus.DATA_IN = '0;
        set_win(0, 3, 0, 3, 0, 0);
        repeat (3) tick();
        check_zero_outputs("reset");
        // release inside a frame: it must be ignored
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.DATA_IN = DW'(i + 1);
            tick();
        end
        bus.LINE_VALID = 1'b0;
        tick();
        end_frame(1'b0);

        npix = 0; fs_data = -1;
        setup_frame(3, 2, 0);
        run_frame(1, -1, -1);
        chk("t1_npix", npix, 6);
        chk("t1_first", fs_data, 11);
        chk("t1_last", last_data, 32);
        chk("t1_count", int'(bus.FRAME_COUNT), 1);

        npix = 0;
        set_win(1, 1, 1, 2, 0, 0);
        run_frame(1, -1, -1);
        chk("t2_npix", npix, 2);
        chk("t2_first", fs_data, 22);
        chk("t2_last", last_data, 32);

        npix = 0;
        set_win(0, 3, 0, 3, 1, 1);
        setup_frame(4, 4, 1);
        run_frame(1, -1, -1);
        chk("t3_npix", npix, 4);
        chk("t3_first", fs_data, 0);
        chk("t3_last", last_data, 22);

        npix = 0;
        set_win(0, 3, 0, 3, 0, 0);
        setup_frame(3, 2, 0);
        run_frame(1, 1, 1);
        chk("t4_npix", npix, 3);
        chk("t4_count", int'(bus.FRAME_COUNT), 4);

        setup_frame(1, 5, 2);
        run_frame(1, -1, -1);
        chk("t5_geom", int'(bus.GEOM_ERROR), 1);
        setup_frame(2, 2, 2);
        run_frame(1, -1, -1);
        chk("t5_geom_cleared", int'(bus.GEOM_ERROR), 0);

        npix = 0;
        setup_frame(2, 3, 2);
        run_frame(0, -1, -1);
        chk("t6_npix", npix, 0);
        chk("t6_count", int'(bus.FRAME_COUNT), 6);
        run_frame(1, -1, -1);
        chk("t6_next_count", int'(bus.FRAME_COUNT), 7);

        // reset in the middle of an active frame
        bus.ENABLE = 1'b1;
        bus.FRAME_VALID = 1'b1;
        bus.LINE_VALID = 1'b0;
        tick();
        bus.LINE_VALID = 1'b1;
        tick();
        RESET = 1'b1;
        pq.delete(); eq.delete();
        fc_m = 0; err_m = 1'b0;
        #1;
        check_zero_outputs("mid_reset");
        tick();
        RESET = 1'b0;
        repeat (3) tick();
        bus.LINE_VALID = 1'b0;
        tick();
        end_frame(1'b0);
        setup_frame(2, 2, 0);
        run_frame(1, -1, -1);
        chk("after_reset_count", int'(bus.FRAME_COUNT), 1);

        for (int f = 0; f < 60; f++) begin
            int dy, dxp;
            set_win($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom), 1'($urandom));
            setup_frame($urandom_range(1, 5), 1, 2);
            for (int y = 0; y < 8; y++) flen[y] = $urandom_range(1, 5);
            dy = -1; dxp = -1;
            if ($urandom_range(0, 4) == 0) begin
                dy  = $urandom_range(0, nl - 1);
                dxp = $urandom_range(0, flen[dy] - 1);
            end
            run_frame($urandom_range(0, 4) != 0, dy, dxp);
        end

        repeat (3) tick();
        chk("pixels_left", pq.size(), 0);
        chk("ends_left", eq.size(), 0);
        chk("final_count", int'(bus.FRAME_COUNT), fc_m);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/camera_window_capture.md
# camera_window_capture

Parametrised successor to the MT9V034 pixel-capture front end. It samples the sensor's parallel bus (data, LINE_VALID, FRAME_VALID) on PIXCLK. It applies a per-frame crop window and optional 2x decimation, and emits pixels with window-relative line/column coordinates. It also reports frame-boundary pulses, a frame counter and a sticky geometry error. It sits between the sensor pins and the downstream frame buffer/processing chain.

## Interface
- DATA_WIDTH, 10, pixel bit width
- MAX_COLS, 752, maximum raw pixels per line; COL_BITS = $clog2(MAX_COLS)
- MAX_LINES, 480, maximum raw lines per frame; LINE_BITS = $clog2(MAX_LINES)
- FCNT_WIDTH, 8, frame counter width
- PIXCLK  in  1  sensor pixel clock; the only clock
- RESET  in  1  asynchronous, active-high reset
- ENABLE  in  1  capture enable, sampled only at frame start
- LINE_VALID  in  1  sensor line valid
- FRAME_VALID  in  1  sensor frame valid
- DATA_IN  in  DATA_WIDTH  sensor pixel data
- WIN_X0, WIN_W  in  COL_BITS  window first raw column / width in raw pixels
- WIN_Y0, WIN_H  in  LINE_BITS  window first raw line / height in raw lines
- DECIM_X, DECIM_Y  in  1  keep every 2nd column / line inside the window
- DATA_OUT  out  DATA_WIDTH  captured pixel
- CURRENT_LINE  out  LINE_BITS  output line index within the window, post-decimation
- CURRENT_COLUMN  out  COL_BITS  output column index within the window, post-decimation
- PIXEL_VALID  out  1  DATA_OUT and the coordinates are valid this cycle
- FRAME_START  out  1  one-cycle pulse coincident with the first PIXEL_VALID of a frame
- FRAME_END  out  1  one-cycle pulse at the end of a captured frame
- FRAME_COUNT  out  FCNT_WIDTH  completed captured frames
- GEOM_ERROR  out  1  sticky per frame: raw geometry exceeded MAX_COLS/MAX_LINES

## Operation
- FSM states:
  - WAIT_IDLE (entered on reset): stay until FRAME_VALID is sampled low; a frame already in progress at reset is ignored.
  - ARMED: on sampled FRAME_VALID rising edge with ENABLE=1, go to ACTIVE. If ENABLE=0, that frame is skipped: go to WAIT_IDLE.
  - ACTIVE: on sampled FRAME_VALID=0, pulse FRAME_END, increment FRAME_COUNT (wraps modulo 2^FCNT_WIDTH), go to ARMED.
- Window and decimation inputs are latched on entry to ACTIVE. Changes mid-frame have no effect until the next frame.
- Raw counters:
  - Raw column x increments for each cycle with LINE_VALID && FRAME_VALID, and clears when LINE_VALID is sampled low.
  - Raw line y increments on each sampled LINE_VALID falling edge. It clears on entry to ACTIVE.
- A pixel at (x,y) is output when all of the following hold:
  - X0 <= x < X0+W and Y0 <= y < Y0+H
  - ((x-X0) bit0 == 0 or !DECIM_X) and ((y-Y0) bit0 == 0 or !DECIM_Y)
- Output coordinates: CURRENT_COLUMN = (x-X0)>>DECIM_X; CURRENT_LINE = (y-Y0)>>DECIM_Y.
- Window comparisons use one extra bit so that X0+W and Y0+H do not overflow.
- W=0 or H=0: no pixels are output. FRAME_END and FRAME_COUNT still update.
- A window extending past the real frame outputs only the pixels that exist. This is not an error.
- Overflow:
  - x reaching MAX_COLS or y reaching MAX_LINES sets GEOM_ERROR. Further pixels are dropped and the counters saturate.
  - GEOM_ERROR clears on the next ACTIVE entry.
- FRAME_VALID falling mid-line terminates the line and the frame together; it does not count as a line increment.
- FRAME_START is asserted with the first output pixel only. A frame with an empty window has no FRAME_START.

## Timing
- Inputs are sampled on the PIXCLK rising edge. All outputs are registered, with 1 cycle of latency from sample to output.
- PIXEL_VALID/DATA_OUT are asserted the cycle after the qualifying sample. PIXEL_VALID is high for exactly one cycle per output pixel.
- FRAME_END is asserted the cycle after FRAME_VALID is first sampled low in ACTIVE. FRAME_COUNT shows the new value in the same cycle.
- Back-to-back frames: FRAME_VALID low for a single cycle is sufficient to arm the next frame.
- Reset values: all outputs 0, FSM in WAIT_IDLE, counters 0.
- Reset asserted mid-ACTIVE aborts the frame immediately: no FRAME_END is produced and FRAME_COUNT returns to 0.

## Test plan
- Reset mid-frame with LV=FV=1, then a 2x3 frame (11,12 / 21,22 / 31,32), full window, MAX_COLS=4, MAX_LINES=4.
  - Ignored portion: no PIXEL_VALID before FV goes low.
  - Captured frame: 6 pixels at (line,col) (0,0)=11 … (2,1)=32, FRAME_START with 11, FRAME_END once, FRAME_COUNT=1.
- Same frame with X0=1, W=1, Y0=1, H=2 -> exactly 2 pixels: 22 at (0,0) and 32 at (1,0).
- 4x4 frame with data = 10*y+x, DECIM_X=DECIM_Y=1, full window -> exactly 4 pixels: 0@(0,0), 2@(0,1), 20@(1,0), 22@(1,1).
- FV drops during the 2nd pixel of line 1 -> FRAME_END the next cycle, FRAME_COUNT increments, no further PIXEL_VALID.
- 5-pixel line with MAX_COLS=4 -> 5th pixel dropped, GEOM_ERROR=1 until the next frame start, after which it reads 0.
- ENABLE=0 at FV rise, raised mid-frame -> no output for that frame and FRAME_COUNT is unchanged; the next frame is captured normally.
